// File: rtl/spi_xfer_sequencer_if.sv
// Core-side request/response bundle of the SPI transfer sequencer.
// master: the core issuing transfer requests; slave: the sequencer.
interface spi_xfer_sequencer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DIV_WIDTH  = 8
);
    logic                  start;
    logic [1:0]            data_len;
    logic                  bit_order;
    logic [DIV_WIDTH-1:0]  clk_div;
    logic [DATA_WIDTH-1:0] tx_data;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  busy;
    logic                  done;

    modport master (
        output start, data_len, bit_order, clk_div, tx_data,
        input  rx_data, busy, done
    );

    modport slave (
        input  start, data_len, bit_order, clk_div, tx_data,
        output rx_data, busy, done
    );
endinterface

// File: rtl/spi_xfer_sequencer.sv
// SPI master transfer sequencer, mode 0 (CPOL=0, CPHA=0).
// Sends an 8/16/24-bit field of tx_data MSB- or LSB-first and assembles
// the MISO bits into a right-aligned receive word.
module spi_xfer_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_xfer_sequencer_if.slave  bus,
    output logic                 sclk,
    output logic                 mosi,
    input  logic                 miso,
    output logic                 cs_n
);
    // Index width into the data word; DATA_WIDTH >= 24 keeps this >= 5 bits,
    // so the bit count 24 also fits.
    localparam int IW = $clog2(DATA_WIDTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEAD  = 3'd1;
    localparam logic [2:0] S_HIGH  = 3'd2;
    localparam logic [2:0] S_LOW   = 3'd3;
    localparam logic [2:0] S_TRAIL = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [DIV_WIDTH:0] HCNT_ONE = 1;

    logic [2:0]            state;
    // One bit wider than clk_div so an all-ones divider never wraps.
    logic [DIV_WIDTH:0]    hcnt;
    logic [DIV_WIDTH-1:0]  div_q;
    logic [IW-1:0]         nbits;
    logic [IW-1:0]         bit_cnt;
    logic                  order_q;
    logic [DATA_WIDTH-1:0] tx_q;
    logic [DATA_WIDTH-1:0] rx_sh;
    logic [DATA_WIDTH-1:0] rx_q;
    logic                  sclk_q;
    logic                  mosi_q;
    logic                  cs_n_q;
    logic                  busy_q;
    logic                  done_q;

    logic                  phase_end;
    logic                  last_bit;
    logic [IW-1:0]         cur_idx;
    logic [IW-1:0]         next_idx;
    logic [IW-1:0]         start_nbits;
    logic [IW-1:0]         first_idx;

    function automatic logic [IW-1:0] decode_len(input logic [1:0] code);
        case (code)
            2'b00:   return IW'(24);
            2'b01:   return IW'(16);
            2'b10:   return IW'(8);
            default: return '0;
        endcase
    endfunction

    // Position in the field of the k-th serial bit for the given order.
    function automatic logic [IW-1:0] field_idx(input logic          order,
                                                input logic [IW-1:0] n,
                                                input logic [IW-1:0] k);
        return order ? k : (n - IW'(1) - k);
    endfunction

    // Phase timing and bit-position decode shared by the sequencer.
    always_comb begin
        phase_end   = (hcnt == {1'b0, div_q});
        last_bit    = (bit_cnt == nbits - IW'(1));
        cur_idx     = field_idx(order_q, nbits, bit_cnt);
        next_idx    = field_idx(order_q, nbits, bit_cnt + IW'(1));
        start_nbits = decode_len(bus.data_len);
        first_idx   = field_idx(bus.bit_order, start_nbits, '0);
    end

    // Transfer sequencer: pin outputs are registered alongside the state so
    // sclk/cs_n/mosi never glitch on state decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            hcnt    <= '0;
            div_q   <= '0;
            nbits   <= '0;
            bit_cnt <= '0;
            order_q <= 1'b0;
            tx_q    <= '0;
            rx_sh   <= '0;
            rx_q    <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        tx_q    <= bus.tx_data;
                        order_q <= bus.bit_order;
                        div_q   <= bus.clk_div;
                        nbits   <= start_nbits;
                        hcnt    <= '0;
                        bit_cnt <= '0;
                        rx_sh   <= '0;
                        if (start_nbits == '0) begin
                            // Zero-length request: complete without touching the pins.
                            state  <= S_DONE;
                            done_q <= 1'b1;
                            rx_q   <= '0;
                        end else begin
                            state  <= S_LEAD;
                            cs_n_q <= 1'b0;
                            busy_q <= 1'b1;
                            mosi_q <= bus.tx_data[first_idx];
                        end
                    end
                end

                S_LEAD, S_LOW: begin
                    if (phase_end) begin
                        // MISO is captured on the edge that raises sclk.
                        state          <= S_HIGH;
                        sclk_q         <= 1'b1;
                        rx_sh[cur_idx] <= miso;
                        hcnt           <= '0;
                    end else begin
                        hcnt <= hcnt + HCNT_ONE;
                    end
                end

                S_HIGH: begin
                    if (phase_end) begin
                        sclk_q <= 1'b0;
                        hcnt   <= '0;
                        if (last_bit) begin
                            state <= S_TRAIL;
                        end else begin
                            state   <= S_LOW;
                            bit_cnt <= bit_cnt + IW'(1);
                            mosi_q  <= tx_q[next_idx];
                        end
                    end else begin
                        hcnt <= hcnt + HCNT_ONE;
                    end
                end

                S_TRAIL: begin
                    if (phase_end) begin
                        state  <= S_DONE;
                        cs_n_q <= 1'b1;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        mosi_q <= 1'b0;
                        rx_q   <= rx_sh;
                        hcnt   <= '0;
                    end else begin
                        hcnt <= hcnt + HCNT_ONE;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state  <= S_IDLE;
                    sclk_q <= 1'b0;
                    mosi_q <= 1'b0;
                    cs_n_q <= 1'b1;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign sclk        = sclk_q;
    assign mosi        = mosi_q;
    assign cs_n        = cs_n_q;
    assign bus.rx_data = rx_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: doc/spi_xfer_sequencer.md
# spi_xfer_sequencer

SPI master transfer sequencer. It accepts one transfer request at a time, with a length code and a bit-order select. It then drives chip-select, SCLK (mode 0: CPOL=0, CPHA=0) and MOSI over the selected 24/16/8-bit field, and assembles the MISO bits into a right-aligned receive word. It sits between the core-side SPI register interface and the pins, and sequences the bit-order/length datapath cycle by cycle.

## Interface
- DATA_WIDTH, 32, width of tx_data/rx_data; must be ≥ 24
- DIV_WIDTH, 8, width of clk_div
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request; accepted only when busy=0
- data_len  in  2  length code: 00→24 bits, 01→16, 10→8, 11→0 bits
- bit_order  in  1  0: MSB of field first; 1: LSB (bit 0) first
- clk_div  in  DIV_WIDTH  SCLK half-period minus one, in clk cycles
- tx_data  in  DATA_WIDTH  transmit word; only bits [N-1:0] used
- rx_data  out  DATA_WIDTH  received word, right-aligned, bits [DATA_WIDTH-1:N] zero
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- sclk  out  1  SPI clock, idle low
- mosi  out  1  serial data out
- miso  in  1  serial data in; synchronous to clk (no synchronizer inside)
- cs_n  out  1  chip select, active low

## Operation
- States: IDLE, LEAD, HIGH, LOW, TRAIL, DONE.
- **IDLE:** start=1 latches tx_data, data_len, bit_order and clk_div. Let N = decoded length and H = clk_div+1.
  - N>0: go to LEAD.
  - N=0: go to DONE directly. No cs_n or sclk activity; rx_data cleared to 0.
- **LEAD:** cs_n=0, sclk=0, mosi=first bit. After H cycles go to HIGH.
- **HIGH:** sclk=1. MISO is sampled into the receive shifter on the cycle sclk is driven 1. After H cycles:
  - bits remain: go to LOW, sclk=0, mosi advances to the next bit in the same cycle;
  - otherwise: go to TRAIL, sclk=0.
- **LOW:** sclk=0. After H cycles go to HIGH.
- **TRAIL:** cs_n=0, sclk=0 for H cycles, then go to DONE.
- **DONE:** one cycle.
  - cs_n=1, done=1, busy=0, mosi=0.
  - rx_data is updated in this cycle and holds until the next DONE or reset.
  - Next state IDLE. start is not accepted in the DONE cycle.
- **Bit order:**
  - bit_order=0: transmit tx_data[N-1] down to tx_data[0]; the first received bit lands in rx_data[N-1].
  - bit_order=1: transmit tx_data[0] up to tx_data[N-1]; the first received bit lands in rx_data[0].
- start while busy=1 is ignored. Changes to inputs after acceptance have no effect on the current transfer.
- The half-period counter is DIV_WIDTH+1 bits wide, so clk_div = all-ones does not wrap.

## Timing
- Reset values: sclk=0, cs_n=1, mosi=0, busy=0, done=0, rx_data=0, state IDLE.
- rst mid-transfer: on the next edge all outputs return to their reset values. No done pulse; the partial rx word is discarded.
- Start accepted at edge T:
  - busy=1 and cs_n=0 from cycle T+1, for (2N+1)·H cycles;
  - DONE occurs in cycle T+1+(2N+1)·H.
- Example: N=8, clk_div=0 gives busy for 17 cycles and done at T+18.
- N=0: DONE occurs in cycle T+1 with busy never asserted.
- Throughput: the earliest next acceptance is in the cycle after DONE.
- SCLK frequency is clk/(2H). Exactly N rising edges occur per transfer.
- MOSI changes only on sclk falling transitions or on LEAD entry, which gives a half-period setup to each rising edge.

## Test plan
- **Loopback, MSB-first:** miso=mosi, data_len=10, bit_order=0, clk_div=0, tx=0x000000C3.
  - Expected: 8 sclk pulses; mosi sequence 1,1,0,0,0,0,1,1; rx_data=0x000000C3; done at T+18.
- **Slave model, 8-bit, both orders:** slave drives miso=0,0,0,0,0,0,0,1.
  - bit_order=0: rx_data=0x01.
  - bit_order=1: rx_data=0x80.
- **24-bit LSB-first loopback, clk_div=3:** tx=0xFF123456.
  - Expected: rx_data=0x00123456; sclk high and low phases each 4 cycles; busy for 196 cycles.
- **16-bit MSB-first loopback:** tx=0xABCD1234.
  - Expected: rx_data=0x00001234; exactly 16 rising sclk edges while cs_n=0.
- **Zero length and busy rejection:**
  - data_len=11: done one cycle after start, busy stays 0, cs_n stays 1.
  - Second start pulsed mid-transfer: ignored, and only one done is produced.
- **Reset mid-transfer:** rst asserted after the 5th sclk rise of an 8-bit transfer.
  - Expected next cycle: cs_n=1, sclk=0, busy=0, rx_data=0, no done.
  - A new transfer then completes normally.
